// File: rtl/uart_rx_fc_pkg.sv
// Shared UART receive definitions: line levels, frame width, FSM states.
package uart_rx_fc_pkg;

    localparam int   DATA_BITS = 8;
    localparam int   BIT_CW    = $clog2(DATA_BITS);
    localparam logic IDLE_LVL  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous receive FIFO with show-ahead head and next-count output.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [$clog2(DEPTH):0]   o_count_nxt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;

    logic w_rd;
    logic w_wr;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_rd    = i_pop && !o_empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign w_wr    = i_push && (!o_full || w_rd);

    assign o_count     = r_cnt;
    assign o_count_nxt = r_cnt + CW'(w_wr) - CW'(w_rd);
    assign o_data      = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_cnt <= o_count_nxt;
        end
    end

endmodule

// File: rtl/uart_rx_fc.sv
// 8N1 UART receiver with receive FIFO, valid/ready output and RTS flow control.
module uart_rx_fc
    import uart_rx_fc_pkg::*;
#(
    parameter int CLK_DIV    = 104,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic       rts,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int BW = $clog2(CLK_DIV);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] L_FULL = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] L_HALF = BW'(CLK_DIV / 2 - 1);

    rx_state_t             r_state;
    logic                  r_rx_m;
    logic                  r_rx_s;
    logic [BW-1:0]         r_baud;
    logic [BIT_CW-1:0]     r_bit;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_ferr;
    logic                  r_ovr;
    logic                  r_rts;

    logic                  w_stop_smp;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [DATA_BITS-1:0]  w_head;

    assign w_stop_smp = (r_state == S_STOP) && (r_baud == L_FULL);
    assign w_push     = w_stop_smp && (r_rx_s == IDLE_LVL);
    assign w_pop      = !w_empty && rd_ready;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_BITS)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .i_push      (w_push),
        .i_data      (r_shift),
        .i_pop       (w_pop),
        .o_data      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_cnt),
        .o_count_nxt (w_cnt_nxt)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_m <= IDLE_LVL;
            r_rx_s <= IDLE_LVL;
        end else begin
            r_rx_m <= rx;
            r_rx_s <= r_rx_m;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ferr  <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (r_rx_s != IDLE_LVL) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_baud == L_HALF) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= (r_rx_s == IDLE_LVL) ? S_IDLE : S_DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (r_baud == L_FULL) begin
                        r_baud  <= '0;
                        r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit   <= r_bit + BIT_CW'(1);
                        if (r_bit == BIT_CW'(DATA_BITS - 1)) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_STOP: begin
                    if (r_baud == L_FULL) begin
                        r_baud <= '0;
                        if (r_rx_s == IDLE_LVL) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    // A held-low break must not look like a new start bit.
                    if (r_rx_s == IDLE_LVL) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ovr <= 1'b0;
            r_rts <= 1'b0;
        end else begin
            r_ovr <= w_push && w_full && !w_pop;
            // One slot of slack covers a frame already in flight.
            r_rts <= (w_cnt_nxt < CW'(FIFO_DEPTH - 1));
        end
    end

    assign rts       = r_rts;
    assign rd_data   = w_head;
    assign rd_valid  = !w_empty;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx_fc.sv
// Directed self-checking bench for uart_rx_fc at CLK_DIV=4, FIFO_DEPTH=4.
module tb_uart_rx_fc;

    logic       clk;
    logic       resetn;
    logic       rx;
    logic       rts;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       frame_err;
    logic       overrun;

    int n_chk;
    int n_fail;
    int fe_cnt;
    int ov_cnt;
    int fe0;
    int ov0;

    uart_rx_fc #(
        .CLK_DIV    (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rx        (rx),
        .rts       (rts),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
        if (frame_err && overrun) begin
            n_chk++;
            n_fail++;
            $display("FAIL excl got=both exp=one");
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves rx at the stop level just after the 40th edge.
    task automatic send_frame(input logic [7:0] b, input logic stp);
        rx = 1'b0;
        tick(4);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(4);
        end
        rx = stp;
        tick(4);
    endtask

    task automatic send_gap(input logic [7:0] b);
        send_frame(b, 1'b1);
        tick(9);
    endtask

    task automatic read_exp(input string tag, input logic [7:0] b);
        check({tag, "_v"}, rd_valid, 1);
        check({tag, "_d"}, rd_data, b);
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        fe_cnt   = 0;
        ov_cnt   = 0;
        clk      = 1'b0;
        resetn   = 1'b0;
        rx       = 1'b1;
        rd_ready = 1'b0;
        #1;
        check("rst_rts", rts, 0);
        check("rst_vld", rd_valid, 0);
        check("rst_dat", rd_data, 0);
        check("rst_fe", frame_err, 0);
        check("rst_ov", overrun, 0);
        tick(3);
        check("rst_rts_hold", rts, 0);
        resetn = 1'b1;
        tick(1);
        check("rts_up", rts, 1);
        tick(4);

        rd_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        check("a5_early", rd_valid, 0);
        tick(1);
        check("a5_vld", rd_valid, 1);
        check("a5_dat", rd_data, 8'hA5);
        tick(1);
        check("a5_pop", rd_valid, 0);
        tick(8);

        fe0 = fe_cnt;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(12);
        check("gl_vld", rd_valid, 0);
        check("gl_fe", fe_cnt - fe0, 0);
        send_frame(8'h5A, 1'b1);
        tick(1);
        check("gl_nxt_v", rd_valid, 1);
        check("gl_nxt_d", rd_data, 8'h5A);
        tick(8);
        rd_ready = 1'b0;

        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        tick(20);
        check("fe_one", fe_cnt - fe0, 1);
        check("fe_vld", rd_valid, 0);
        rx = 1'b1;
        tick(50);
        check("fe_once", fe_cnt - fe0, 1);
        check("fe_nopush", rd_valid, 0);

        ov0 = ov_cnt;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            tick(1);
            check($sformatf("fc_rts%0d", i), rts, (i < 3) ? 1 : 0);
            check($sformatf("fc_head%0d", i), rd_data, 1);
            tick(8);
        end
        check("fc_ovr", ov_cnt - ov0, 1);
        for (int i = 1; i <= 4; i++) begin
            read_exp($sformatf("dr%0d", i), 8'(i));
            check($sformatf("dr_rts%0d", i), rts, (i >= 2) ? 1 : 0);
        end
        check("dr_empty", rd_valid, 0);

        ov0 = ov_cnt;
        send_gap(8'h11);
        send_gap(8'h22);
        send_gap(8'h33);
        send_gap(8'h44);
        send_frame(8'h77, 1'b1);
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        tick(8);
        check("sp_novr", ov_cnt - ov0, 0);
        check("sp_rts", rts, 0);
        read_exp("sp1", 8'h22);
        read_exp("sp2", 8'h33);
        read_exp("sp3", 8'h44);
        read_exp("sp4", 8'h77);
        check("sp_empty", rd_valid, 0);

        send_gap(8'h99);
        check("pre_rst_v", rd_valid, 1);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(10);
        resetn = 1'b0;
        #1;
        check("mid_rts", rts, 0);
        check("mid_vld", rd_valid, 0);
        check("mid_dat", rd_data, 0);
        check("mid_fe", frame_err, 0);
        check("mid_ov", overrun, 0);
        tick(3);
        resetn = 1'b1;
        tick(1);
        check("rel_rts", rts, 1);
        check("rel_vld", rd_valid, 0);
        tick(4);
        rd_ready = 1'b1;
        send_frame(8'h42, 1'b1);
        tick(1);
        check("r42_vld", rd_valid, 1);
        check("r42_dat", rd_data, 8'h42);
        tick(1);
        check("r42_pop", rd_valid, 0);
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
